// File: rtl/layer_sched.sv
// layer_sched: sequences the layer engines one after another on a single start
// pulse. Each non-skipped engine receives a one-cycle enable and the scheduler
// waits for that engine's done (or a watchdog timeout) before moving on. While
// an engine is being fired or waited on, its DRAM port is muxed onto the shared
// DRAM; DRAM read data is broadcast to every engine.
//
// Ports
//   clk, srst                   clock, synchronous active-high reset
//   start, cfg_skip, cfg_tmo    run request and per-run config (latched on start)
//   eng_enable / eng_done       per-engine enable pulse out, done pulse in
//   eng_addr_rd/_wr, eng_data_wr, eng_en_rd/_wr   packed engine DRAM requests
//   eng_data_rd                 DRAM read data broadcast to engines
//   dram_*                      shared DRAM port (muxed from active engine)
//   cur_eng, busy, done, err    status
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// SEL    | pick next engine: skip masked ones, finish when idx==NUM_ENG
// FIRE   | one-cycle enable to engine idx, clear watchdog
// WAIT   | wait for done of engine idx, count watchdog
// FIN    | run completed normally, pulse done
// ERR    | watchdog expired, pulse done and set err
module layer_sched #(
   parameter int NUM_ENG    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 18,
   parameter int IDX_WIDTH  = 3,
   parameter int TMO_WIDTH  = 20
) (
   input  logic                          clk,
   input  logic                          srst,
   input  logic                          start,
   input  logic [NUM_ENG-1:0]            cfg_skip,
   input  logic [TMO_WIDTH-1:0]          cfg_tmo,
   output logic [NUM_ENG-1:0]            eng_enable,
   input  logic [NUM_ENG-1:0]            eng_done,
   input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_rd,
   input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_wr,
   input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_wr,
   input  logic [NUM_ENG-1:0]            eng_en_rd,
   input  logic [NUM_ENG-1:0]            eng_en_wr,
   output logic [DATA_WIDTH-1:0]         eng_data_rd,
   input  logic [DATA_WIDTH-1:0]         dram_data_rd,
   output logic [ADDR_WIDTH-1:0]         dram_addr_rd,
   output logic [ADDR_WIDTH-1:0]         dram_addr_wr,
   output logic [DATA_WIDTH-1:0]         dram_data_wr,
   output logic                          dram_en_rd,
   output logic                          dram_en_wr,
   output logic [IDX_WIDTH-1:0]          cur_eng,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_FIRE, S_WAIT, S_FIN, S_ERR
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;
   logic [TMO_WIDTH-1:0]   timer_q, timer_d;
   logic [TMO_WIDTH-1:0]   tmo_q, tmo_d;
   logic [NUM_ENG-1:0]     skip_q, skip_d;
   logic                   err_q, err_d;

   logic                   cur_skip;
   logic                   cur_done;
   logic [ADDR_WIDTH-1:0]  sel_addr_rd;
   logic [ADDR_WIDTH-1:0]  sel_addr_wr;
   logic [DATA_WIDTH-1:0]  sel_data_wr;
   logic                   sel_en_rd;
   logic                   sel_en_wr;
   logic                   idx_end;

   // Select everything belonging to engine idx; compare-based so the index
   // register may be wider than log2(NUM_ENG) without out-of-range selects.
   always_comb begin
      cur_skip    = 1'b0;
      cur_done    = 1'b0;
      sel_addr_rd = '0;
      sel_addr_wr = '0;
      sel_data_wr = '0;
      sel_en_rd   = 1'b0;
      sel_en_wr   = 1'b0;
      for (int i = 0; i < NUM_ENG; i++) begin
         if (idx_q == IDX_WIDTH'(i)) begin
            cur_skip    = skip_q[i];
            cur_done    = eng_done[i];
            sel_addr_rd = eng_addr_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_addr_wr = eng_addr_wr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data_wr = eng_data_wr[i*DATA_WIDTH +: DATA_WIDTH];
            sel_en_rd   = eng_en_rd[i];
            sel_en_wr   = eng_en_wr[i];
         end
      end
   end

   assign idx_end = (idx_q == IDX_WIDTH'(NUM_ENG));

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         timer_q <= '0;
         tmo_q   <= '0;
         skip_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         timer_q <= timer_d;
         tmo_q   <= tmo_d;
         skip_q  <= skip_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      timer_d = timer_q;
      tmo_d   = tmo_q;
      skip_d  = skip_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               skip_d  = cfg_skip;
               tmo_d   = cfg_tmo;
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = S_SEL;
            end
         end
         S_SEL: begin
            if (idx_end)       state_d = S_FIN;
            else if (cur_skip) idx_d   = idx_q + 1'b1;
            else               state_d = S_FIRE;
         end
         S_FIRE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done is checked first so it wins over a coincident timeout
            if (cur_done) begin
               idx_d   = idx_q + 1'b1;
               state_d = S_SEL;
            end else if ((tmo_q != '0) && (timer_q == tmo_q - 1'b1)) begin
               state_d = S_ERR;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_FIN:   state_d = S_IDLE;
         S_ERR: begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic active;

   always_comb begin
      eng_enable = '0;
      for (int i = 0; i < NUM_ENG; i++) begin
         if ((state_q == S_FIRE) && (idx_q == IDX_WIDTH'(i))) eng_enable[i] = 1'b1;
      end
      active       = (state_q == S_FIRE) || (state_q == S_WAIT);
      busy         = (state_q != S_IDLE);
      done         = (state_q == S_FIN) || (state_q == S_ERR);
      err          = err_q;
      cur_eng      = idx_q;
      dram_addr_rd = active ? sel_addr_rd : '0;
      dram_addr_wr = active ? sel_addr_wr : '0;
      dram_data_wr = active ? sel_data_wr : '0;
      dram_en_rd   = active & sel_en_rd;
      dram_en_wr   = active & sel_en_wr;
   end

   assign eng_data_rd = dram_data_rd;

endmodule

// File: tb/tb_layer_sched.sv
module tb_layer_sched;
   localparam int NE = 4;
   localparam int DW = 32;
   localparam int AW = 18;
   localparam int IW = 3;
   localparam int TW = 20;

   logic              clk = 1'b0;
   logic              srst = 1'b1;
   logic              start = 1'b0;
   logic [NE-1:0]     cfg_skip = '0;
   logic [TW-1:0]     cfg_tmo = '0;
   logic [NE-1:0]     eng_enable;
   logic [NE-1:0]     eng_done;
   logic [NE*AW-1:0]  eng_addr_rd = '0;
   logic [NE*AW-1:0]  eng_addr_wr = '0;
   logic [NE*DW-1:0]  eng_data_wr = '0;
   logic [NE-1:0]     eng_en_rd = '0;
   logic [NE-1:0]     eng_en_wr = '0;
   logic [DW-1:0]     eng_data_rd;
   logic [DW-1:0]     dram_data_rd = '0;
   logic [AW-1:0]     dram_addr_rd;
   logic [AW-1:0]     dram_addr_wr;
   logic [DW-1:0]     dram_data_wr;
   logic              dram_en_rd;
   logic              dram_en_wr;
   logic [IW-1:0]     cur_eng;
   logic              busy;
   logic              done;
   logic              err;

   layer_sched #(.NUM_ENG(NE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                 .IDX_WIDTH(IW), .TMO_WIDTH(TW)) dut (
      .clk(clk), .srst(srst), .start(start), .cfg_skip(cfg_skip), .cfg_tmo(cfg_tmo),
      .eng_enable(eng_enable), .eng_done(eng_done),
      .eng_addr_rd(eng_addr_rd), .eng_addr_wr(eng_addr_wr), .eng_data_wr(eng_data_wr),
      .eng_en_rd(eng_en_rd), .eng_en_wr(eng_en_wr), .eng_data_rd(eng_data_rd),
      .dram_data_rd(dram_data_rd), .dram_addr_rd(dram_addr_rd), .dram_addr_wr(dram_addr_wr),
      .dram_data_wr(dram_data_wr), .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr),
      .cur_eng(cur_eng), .busy(busy), .done(done), .err(err));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // stub engines: done pulse 10 cycles after enable, unless hung
   int            cnt [NE];
   logic [NE-1:0] hang = '0;
   logic [NE-1:0] spur = '0;
   logic [NE-1:0] stub_done;
   always @(posedge clk) begin
      for (int i = 0; i < NE; i++) begin
         if (srst)               cnt[i] <= -1;
         else if (eng_enable[i]) cnt[i] <= 9;
         else if (cnt[i] >= 0)   cnt[i] <= cnt[i] - 1;
      end
   end
   always_comb begin
      stub_done = '0;
      for (int i = 0; i < NE; i++) stub_done[i] = (cnt[i] == 0) && !hang[i];
   end
   assign eng_done = stub_done | spur;

   // event monitor, sampled mid-cycle
   int en_idx[$];
   int en_t[$];
   int done_t[$];
   int busy_cnt;
   int bad_cur;
   int bad_hot;
   always @(negedge clk) begin
      if (eng_enable != '0) begin
         for (int i = 0; i < NE; i++) if (eng_enable[i]) begin
            en_idx.push_back(i);
            en_t.push_back(cyc);
            if (int'(cur_eng) != i) bad_cur++;
         end
         if (!$onehot(eng_enable)) bad_hot++;
      end
      if (done) done_t.push_back(cyc);
      if (busy) busy_cnt++;
   end

   int n_chk = 0;
   int n_fail = 0;
   int t0 = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic go_to(input int rel);
      for (int k = 0; k < 1000 && cyc < t0 + rel; k++) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " eng_enable"}, eng_enable, 0);
      chk({tag, " dram_addr_rd"}, dram_addr_rd, 0);
      chk({tag, " dram_addr_wr"}, dram_addr_wr, 0);
      chk({tag, " dram_data_wr"}, dram_data_wr, 0);
      chk({tag, " dram_en"}, {dram_en_rd, dram_en_wr}, 0);
   endtask

   typedef struct {
      logic [NE-1:0]    skip;
      logic [TW-1:0]    tmo;
      logic [NE-1:0]    hang;
      logic [NE-1:0]    spur;
      int               n_en;
      bit [3:0][2:0]    ei;
      bit [3:0][7:0]    et;
      int               done_rel;
      bit               err_exp;
   } vec_t;

   vec_t vecs [7];

   task automatic run_vec(input int vi, input vec_t v);
      bit got_done;
      @(negedge clk);
      en_idx.delete(); en_t.delete(); done_t.delete();
      busy_cnt = 0; bad_cur = 0; bad_hot = 0;
      cfg_skip = v.skip; cfg_tmo = v.tmo; hang = v.hang;
      start = 1'b1;
      t0 = cyc;
      got_done = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         start = (cyc - t0 == 4);   // ignored: scheduler is busy
         spur  = (cyc - t0 == 5) ? v.spur : '0;
         if (cyc - t0 == 1) chk($sformatf("v%0d err cleared on start", vi), err, 0);
         if (done_t.size() > 0 && cyc >= done_t[0] + 2) begin
            got_done = 1'b1;
            break;
         end
      end
      start = 1'b0; spur = '0;
      chk($sformatf("v%0d run completed", vi), got_done, 1);
      if (got_done) begin
         chk($sformatf("v%0d done time", vi), done_t[0] - t0, v.done_rel);
         chk($sformatf("v%0d done pulses", vi), done_t.size(), 1);
         chk($sformatf("v%0d err", vi), err, v.err_exp);
         chk($sformatf("v%0d busy cycles", vi), busy_cnt, v.done_rel);
         chk($sformatf("v%0d idle after", vi), busy, 0);
      end
      chk($sformatf("v%0d enable count", vi), en_idx.size(), v.n_en);
      for (int j = 0; j < v.n_en && j < en_idx.size(); j++) begin
         chk($sformatf("v%0d enable %0d idx", vi, j), en_idx[j], v.ei[j]);
         chk($sformatf("v%0d enable %0d time", vi, j), en_t[j] - t0, v.et[j]);
      end
      chk($sformatf("v%0d cur_eng at enable", vi), bad_cur, 0);
      chk($sformatf("v%0d enable onehot", vi), bad_hot, 0);
   endtask

   initial begin
      vecs[0] = '{4'b0000, 20'd0,  4'b0000, 4'b1110, 4, {3'd3,3'd2,3'd1,3'd0}, {8'd38,8'd26,8'd14,8'd2}, 50, 1'b0};
      vecs[1] = '{4'b0101, 20'd0,  4'b0000, 4'b1101, 2, {3'd0,3'd0,3'd3,3'd1}, {8'd0,8'd0,8'd16,8'd3},   28, 1'b0};
      vecs[2] = '{4'b1111, 20'd0,  4'b0000, 4'b0000, 0, '0, '0, 6, 1'b0};
      vecs[3] = '{4'b0000, 20'd50, 4'b0100, 4'b1110, 3, {3'd0,3'd2,3'd1,3'd0}, {8'd0,8'd26,8'd14,8'd2},  77, 1'b1};
      vecs[4] = '{4'b1000, 20'd0,  4'b0000, 4'b1110, 3, {3'd0,3'd2,3'd1,3'd0}, {8'd0,8'd26,8'd14,8'd2},  39, 1'b0};
      vecs[5] = '{4'b0000, 20'd10, 4'b0000, 4'b1110, 4, {3'd3,3'd2,3'd1,3'd0}, {8'd38,8'd26,8'd14,8'd2}, 50, 1'b0};
      vecs[6] = '{4'b0000, 20'd9,  4'b0000, 4'b1110, 1, {3'd0,3'd0,3'd0,3'd0}, {8'd0,8'd0,8'd0,8'd2},    12, 1'b1};

      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      chk("reset cur_eng", cur_eng, 0);
      chk_all_zero("reset");
      srst = 1'b0;
      repeat (2) @(negedge clk);

      for (int vi = 0; vi < 7; vi++) run_vec(vi, vecs[vi]);

      // DRAM mux: only engine 1 runs, the others drive junk with writes enabled
      @(negedge clk);
      for (int i = 0; i < NE; i++) begin
         eng_addr_rd[i*AW +: AW] = 18'h3FFFF;
         eng_addr_wr[i*AW +: AW] = 18'h3FFFF;
         eng_data_wr[i*DW +: DW] = 32'hDEAD_BEEF;
      end
      eng_addr_rd[1*AW +: AW] = 18'h00123;
      eng_addr_wr[1*AW +: AW] = 18'h00456;
      eng_data_wr[1*DW +: DW] = 32'h1234_5678;
      eng_en_rd = 4'b1111;
      eng_en_wr = 4'b1101;
      cfg_skip = 4'b1101; cfg_tmo = '0; hang = '0;
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      chk_all_zero("mux SEL");
      go_to(3);
      chk("mux FIRE enable", eng_enable, 4'b0010);
      chk("mux FIRE addr_rd", dram_addr_rd, 18'h00123);
      chk("mux FIRE addr_wr", dram_addr_wr, 18'h00456);
      chk("mux FIRE data_wr", dram_data_wr, 32'h1234_5678);
      chk("mux FIRE en", {dram_en_rd, dram_en_wr}, 2'b10);
      go_to(8);
      dram_data_rd = 32'hA5A5_0F0F;
      #1;
      chk("mux WAIT eng_data_rd", eng_data_rd, 32'hA5A5_0F0F);
      chk("mux WAIT addr_rd", dram_addr_rd, 18'h00123);
      chk("mux WAIT data_wr", dram_data_wr, 32'h1234_5678);
      chk("mux WAIT en", {dram_en_rd, dram_en_wr}, 2'b10);
      go_to(15);
      chk("mux late SEL busy", busy, 1);
      chk_all_zero("mux late SEL");
      go_to(17);
      chk("mux FIN done", done, 1);
      chk_all_zero("mux FIN");
      go_to(20);

      // one-cycle srst in the middle of WAIT on engine 2 (after an err run)
      run_vec(6, vecs[6]);
      @(negedge clk);
      cfg_skip = '0; cfg_tmo = '0;
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      go_to(30);
      chk("pre-srst cur_eng", cur_eng, 2);
      srst = 1'b1;
      go_to(31);
      srst = 1'b0;
      chk("srst busy", busy, 0);
      chk("srst done", done, 0);
      chk("srst err", err, 0);
      chk("srst cur_eng", cur_eng, 0);
      chk_all_zero("srst");
      go_to(41);
      run_vec(0, vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
